// File: rtl/rom_loader_if.sv
// Memory-side bus of the power-on loader: dual-port ROM read port and SDRAM write port.
interface rom_loader_if #(
  parameter int unsigned AW   = 19,
  parameter int unsigned ROMW = 16
);
  logic [ROMW-1:0] romA;
  logic [7:0]      romQ;
  logic [AW-1:0]   sdrA;
  logic [7:0]      sdrD;
  logic            sdrWr;

  modport master (
    output romA,
    input  romQ,
    output sdrA,
    output sdrD,
    output sdrWr
  );

  modport slave (
    input  romA,
    output romQ,
    input  sdrA,
    input  sdrD,
    input  sdrWr
  );
endinterface

// File: rtl/rom_loader.sv
// Power-on copy engine: walks the SDRAM byte space once, copying the ROM region
// from the dual-port memory and filling the rest, then raises done.
module rom_loader #(
  parameter int unsigned AW   = 19,
  parameter int unsigned ROMW = 16,
  parameter logic [7:0]  FILL = 8'h00
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             ready,
  output logic             done,
  rom_loader_if.master     mem
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e        st_q, st_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          done_q, done_d;
  logic          advance;
  logic          in_rom;

  assign advance = ce && ready;

  // State, address and done registers; everything holds without a qualified strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= ST_WAIT;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end

  // Next-state and address sequencing
  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    done_d = done_q;
    if (advance) begin
      unique case (st_q)
        ST_WAIT: st_d = ST_RD;
        ST_RD:   st_d = ST_WR;
        ST_WR: begin
          if (addr_q == '1) begin
            st_d   = ST_DONE;
            done_d = 1'b1;
          end else begin
            addr_d = addr_q + AW'(1);
            st_d   = ST_RD;
          end
        end
        ST_DONE: st_d = ST_DONE;
        default: st_d = ST_WAIT;
      endcase
    end
  end

  // Shift instead of slicing so ROMW == AW stays legal (whole space is ROM)
  assign in_rom = ((addr_q >> ROMW) == '0);

  // Memory-side outputs; romA tracks addr in every state so romQ stays stable in WR
  always_comb begin
    mem.romA  = addr_q[ROMW-1:0];
    mem.sdrA  = addr_q;
    mem.sdrD  = in_rom ? mem.romQ : FILL;
    mem.sdrWr = 1'b1;
    if ((st_q == ST_WR) && ready) begin
      mem.sdrWr = 1'b0;
    end
  end

  assign done = done_q;

endmodule
